// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: sequences single ALU operations on an 8-bit accumulator through an external combinational ALU.
// Also holds cpu_alu, the combinational ALU the sequencer is paired with.
// cpu_alu ports: x/y operands, c_in carry-in, op select -> e result, c carry/borrow, z zero, s sign, p even parity.
// cpu_alu_seq ports: CLK_I/RSTN_I clock and async active-low reset, CLR_I sync clear,
//   REQ_* request handshake (op, load-accumulator, operand), ALU_* connection to cpu_alu,
//   ACC_O/FLG_*_O registered accumulator and flags, RES_VLD_O one-cycle completion pulse.
module cpu_alu (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       c_in,
  input  logic [2:0] op,
  output logic [7:0] e,
  output logic       c,
  output logic       z,
  output logic       s,
  output logic       p
);
  logic [8:0] r;
  // Subtraction is done 9 bits wide so bit 8 comes out as the borrow.
  always_comb begin
    r = 9'd0;
    case (op)
      3'b000:         r = {1'b0, x} + {1'b0, y};
      3'b001:         r = {1'b0, x} + {1'b0, y} + {8'd0, c_in};
      3'b010, 3'b111: r = {1'b0, x} - {1'b0, y};
      3'b011:         r = {1'b0, x} - {1'b0, y} - {8'd0, c_in};
      3'b100:         r = {1'b0, x & y};
      3'b101:         r = {1'b0, x ^ y};
      default:        r = {1'b0, x | y};
    endcase
  end
  assign e = r[7:0];
  assign c = r[8];
  assign z = ~|r[7:0];
  assign s = r[7];
  assign p = ~^r[7:0];
endmodule

module cpu_alu_seq (
  input  logic       CLK_I,
  input  logic       RSTN_I,
  input  logic       CLR_I,
  input  logic       REQ_VLD_I,
  output logic       REQ_RDY_O,
  input  logic [2:0] REQ_OP_I,
  input  logic       REQ_LDA_I,
  input  logic [7:0] REQ_DAT_I,
  output logic [7:0] ALU_X_O,
  output logic [7:0] ALU_Y_O,
  output logic       ALU_C_O,
  output logic [2:0] ALU_OP_O,
  input  logic [7:0] ALU_E_I,
  input  logic       ALU_C_I,
  input  logic       ALU_Z_I,
  input  logic       ALU_S_I,
  input  logic       ALU_P_I,
  output logic [7:0] ACC_O,
  output logic       FLG_C_O,
  output logic       FLG_Z_O,
  output logic       FLG_S_O,
  output logic       FLG_P_O,
  output logic       RES_VLD_O
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic       lda_q;
  logic [7:0] dat_q;
  logic [7:0] x_q;
  logic       c_q;
  logic       accept;
  assign accept = (state == IDLE) && REQ_VLD_I && !CLR_I;
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) state <= IDLE;
    else         state <= state_nxt;
  end
  always_comb begin
    state_nxt = CLR_I           ? IDLE :
                state == IDLE   ? (REQ_VLD_I ? EXEC : IDLE) :
                state == EXEC   ? DONE : IDLE;
  end
  always_comb begin
    REQ_RDY_O = state == IDLE;
    RES_VLD_O = state == DONE;
  end
  // ACC and carry are snapshotted at acceptance so the ALU ports stay frozen
  // from EXEC onwards even after ACC/flags update at the end of EXEC.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      op_q  <= 3'd0;
      lda_q <= 1'b0;
      dat_q <= 8'd0;
      x_q   <= 8'd0;
      c_q   <= 1'b0;
    end else if (accept) begin
      op_q  <= REQ_OP_I;
      lda_q <= REQ_LDA_I;
      dat_q <= REQ_DAT_I;
      x_q   <= ACC_O;
      c_q   <= FLG_C_O;
    end
  end
  assign ALU_X_O  = x_q;
  assign ALU_Y_O  = dat_q;
  assign ALU_C_O  = c_q;
  assign ALU_OP_O = op_q;
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      ACC_O   <= 8'd0;
      {FLG_C_O, FLG_Z_O, FLG_S_O, FLG_P_O} <= 4'd0;
    end else if (CLR_I) begin
      ACC_O   <= 8'd0;
      {FLG_C_O, FLG_Z_O, FLG_S_O, FLG_P_O} <= 4'd0;
    end else if (state == EXEC) begin
      if (lda_q) ACC_O <= dat_q;
      else begin
        if (op_q != 3'b111) ACC_O <= ALU_E_I;
        {FLG_C_O, FLG_Z_O, FLG_S_O, FLG_P_O} <= {ALU_C_I, ALU_Z_I, ALU_S_I, ALU_P_I};
      end
    end
  end
endmodule

// File: tb/tb_cpu_alu_seq.sv
// tb_cpu_alu_seq: pairs cpu_alu_seq with cpu_alu and checks it against an arithmetic reference model.
module tb_cpu_alu_seq;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clr = 1'b0;
  logic       vld = 1'b0;
  logic       rdy;
  logic [2:0] op = 3'd0;
  logic       lda = 1'b0;
  logic [7:0] dat = 8'd0;
  logic [7:0] alu_x, alu_y, alu_e, acc;
  logic       alu_c, alu_ci, alu_zi, alu_si, alu_pi;
  logic [2:0] alu_op;
  logic       fc, fz, fs, fp, res_vld;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [7:0] m_acc = 8'd0;
  logic       m_c = 1'b0, m_z = 1'b0, m_s = 1'b0, m_p = 1'b0;
  typedef struct {
    logic [2:0] op;
    logic       lda;
    logic [7:0] dat;
    logic [7:0] acc;
    logic       c, z, s, p;
  } vec_t;
  vec_t tv[4];
  cpu_alu_seq dut (
    .CLK_I(clk), .RSTN_I(rstn), .CLR_I(clr), .REQ_VLD_I(vld), .REQ_RDY_O(rdy),
    .REQ_OP_I(op), .REQ_LDA_I(lda), .REQ_DAT_I(dat),
    .ALU_X_O(alu_x), .ALU_Y_O(alu_y), .ALU_C_O(alu_c), .ALU_OP_O(alu_op),
    .ALU_E_I(alu_e), .ALU_C_I(alu_ci), .ALU_Z_I(alu_zi), .ALU_S_I(alu_si), .ALU_P_I(alu_pi),
    .ACC_O(acc), .FLG_C_O(fc), .FLG_Z_O(fz), .FLG_S_O(fs), .FLG_P_O(fp), .RES_VLD_O(res_vld)
  );
  cpu_alu alu (
    .x(alu_x), .y(alu_y), .c_in(alu_c), .op(alu_op),
    .e(alu_e), .c(alu_ci), .z(alu_zi), .s(alu_si), .p(alu_pi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (res_vld) pulses <= pulses + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic model(input logic [2:0] o, input logic l, input logic [7:0] d);
    int a, b, r;
    logic [7:0] r8;
    a = int'(m_acc);
    b = int'(d);
    if (l) begin
      m_acc = d;
      return;
    end
    case (o)
      3'd0:    r = a + b;
      3'd1:    r = a + b + int'(m_c);
      3'd2:    r = a - b;
      3'd7:    r = a - b;
      3'd3:    r = a - b - int'(m_c);
      3'd4:    r = a & b;
      3'd5:    r = a ^ b;
      default: r = a | b;
    endcase
    m_c = (r < 0) || (r > 255);
    r8 = 8'(r);
    m_z = r8 == 8'd0;
    m_s = r8[7];
    m_p = ($countones(r8) % 2) == 0;
    if (o != 3'd7) m_acc = r8;
  endtask
  task automatic model_clear();
    m_acc = 8'd0;
    {m_c, m_z, m_s, m_p} = 4'd0;
  endtask
  task automatic chk_state(input string nm);
    chk({nm, "_acc"}, acc, m_acc);
    chk({nm, "_flags"}, {fc, fz, fs, fp}, {m_c, m_z, m_s, m_p});
  endtask
  // Presents one request, called at a negedge; returns 1 ns after the edge that ends DONE.
  task automatic run_op(input logic [2:0] o, input logic l, input logic [7:0] d);
    int n = 0;
    op = o; lda = l; dat = d; vld = 1'b1;
    while (!rdy && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) chk("rdy_timeout", 0, 1);
    @(posedge clk);
    #1 vld = 1'b0;
    chk("exec_rdy", rdy, 0);
    chk("exec_vld", res_vld, 0);
    chk("exec_ports", {alu_x, alu_y, alu_c, alu_op}, {m_acc, d, m_c, o});
    model(o, l, d);
    exp_pulses++;
    @(posedge clk);
    #1 chk("done_vld", res_vld, 1);
    chk_state("done");
    @(posedge clk);
    #1 chk("idle_vld", res_vld, 0);
    chk("idle_rdy", rdy, 1);
  endtask
  initial begin
    int last;
    int t;
    tv[0] = '{3'd0, 1'b1, 8'hB3, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{3'd0, 1'b0, 8'h6C, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2] = '{3'd1, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3] = '{3'd7, 1'b0, 8'h20, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", {fc, fz, fs, fp}, 4'd0);
    chk("rst_rdy", rdy, 1);
    chk("rst_vld", res_vld, 0);
    chk("rst_ports", {alu_x, alu_y, alu_c, alu_op}, 20'd0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_op(tv[i].op, tv[i].lda, tv[i].dat);
      chk("tbl_acc", acc, tv[i].acc);
      chk("tbl_flags", {fc, fz, fs, fp}, {tv[i].c, tv[i].z, tv[i].s, tv[i].p});
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(7)), ($urandom_range(5) == 0), 8'($urandom));
      @(negedge clk);
    end
    last = 0;
    vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      logic [2:0] o;
      logic [7:0] d;
      o = 3'($urandom_range(6));
      d = 8'($urandom);
      op = o; lda = 1'b0; dat = d;
      while (!rdy && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!rdy) chk("b2b_timeout", 0, 1);
      if (k > 0) chk("b2b_spacing", cyc - last, 3);
      last = cyc;
      @(posedge clk);
      #1 chk("b2b_ports", {alu_x, alu_y, alu_c, alu_op}, {m_acc, d, m_c, o});
      model(o, 1'b0, d);
      exp_pulses++;
      @(posedge clk);
      #1 chk("b2b_vld", res_vld, 1);
      chk_state("b2b");
      if (k == 3) vld = 1'b0;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("b2b_pulses", pulses, exp_pulses);
    run_op(3'd0, 1'b1, 8'h77);
    @(negedge clk);
    clr = 1'b1; vld = 1'b1; op = 3'd0; lda = 1'b0; dat = 8'h05;
    @(posedge clk);
    #1 chk("clr_idle_rdy", rdy, 1);
    chk("clr_idle_acc", acc, 8'h00);
    model_clear();
    chk_state("clr_idle");
    @(negedge clk);
    clr = 1'b0; vld = 1'b0;
    run_op(3'd0, 1'b1, 8'h55);
    @(negedge clk);
    op = 3'd0; lda = 1'b0; dat = 8'h11; vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    chk("clr_exec_accepted", rdy, 0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr_exec_rdy", rdy, 1);
    chk("clr_exec_vld", res_vld, 0);
    model_clear();
    chk_state("clr_exec");
    repeat (2) @(negedge clk);
    chk("clr_pulses", pulses, exp_pulses);
    run_op(3'd0, 1'b1, 8'h40);
    @(negedge clk);
    op = 3'd0; lda = 1'b0; dat = 8'h01; vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    chk("rst_exec_accepted", rdy, 0);
    rstn = 1'b0;
    #1 chk("rst_async_acc", acc, 8'h00);
    chk("rst_async_rdy", rdy, 1);
    chk("rst_async_ports", {alu_x, alu_y, alu_c, alu_op}, 20'd0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_release_rdy", rdy, 1);
    t = cyc;
    run_op(3'd2, 1'b0, 8'h03);
    chk("rst_first_accept", cyc - t, 3);
    @(negedge clk);
    chk("final_pulses", pulses, exp_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/cpu_alu_seq.md
CPU_ALU_SEQ -- requirements
Module: cpu_alu_seq

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Ports (name  direction  width  meaning):
- CLK_I  in  1  clock; all state changes on the rising edge.
- RSTN_I  in  1  asynchronous, active-low reset.
- CLR_I  in  1  synchronous clear of ACC and flags.
- REQ_VLD_I  in  1  request valid.
- REQ_RDY_O  out  1  ready to accept a request.
- REQ_OP_I  in  3  ALU op: 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 AND, 101 XOR, 110 OR, 111 CMP.
- REQ_LDA_I  in  1  load the accumulator directly; REQ_OP_I is ignored.
- REQ_DAT_I  in  8  operand.
- ALU_X_O  out  8  ALU X port.
- ALU_Y_O  out  8  ALU Y port.
- ALU_C_O  out  1  ALU carry-in.
- ALU_OP_O  out  3  ALU op select.
- ALU_E_I  in  8  ALU result.
- ALU_C_I, ALU_Z_I, ALU_S_I, ALU_P_I  in  1 each  ALU flags.
- ACC_O  out  8  accumulator.
- FLG_C_O, FLG_Z_O, FLG_S_O, FLG_P_O  out  1 each  flag registers.
- RES_VLD_O  out  1  one-cycle completion pulse.
REQ-003 SHALL connect to a combinational cpu_alu through the ALU_* ports; the block SHALL NOT compute arithmetic itself.

Function
REQ-004 SHALL implement the FSM states IDLE, EXEC and DONE, with IDLE as the reset state.
REQ-005 In IDLE, REQ_RDY_O SHALL be 1; in every other state it SHALL be 0.
REQ-006 On REQ_VLD_I=1 and REQ_RDY_O=1 in IDLE, the block SHALL latch REQ_OP_I, REQ_LDA_I and REQ_DAT_I into internal registers and go to EXEC.
REQ-007 In EXEC, the ALU ports SHALL be driven only from registers:
- ALU_X_O = ACC
- ALU_Y_O = latched operand
- ALU_C_O = FLG_C
- ALU_OP_O = latched op
REQ-008 At the end of EXEC, an ALU op other than CMP SHALL load ACC from ALU_E_I and C/Z/S/P from ALU_C_I/ALU_Z_I/ALU_S_I/ALU_P_I; the block then goes to DONE.
REQ-009 For CMP (111), ACC SHALL be unchanged and the four flags SHALL be updated.
REQ-010 For LDA, ACC SHALL load the latched operand, all flags SHALL be unchanged, and the ALU outputs SHALL be ignored.
REQ-011 In DONE, RES_VLD_O SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-012 Latency SHALL be 3 cycles: accept edge to EXEC to DONE, with RES_VLD_O asserted 2 edges after acceptance; the next accept SHALL be possible 3 edges after the previous one.
REQ-013 ACC_O and FLG_*_O SHALL be registered outputs, updated only at the end of EXEC or by CLR_I.
REQ-014 In IDLE and DONE, ALU_* outputs SHALL hold their last values and SHALL NOT glitch.
REQ-015 A request presented while REQ_RDY_O=0 SHALL NOT be accepted and SHALL NOT be lost; the requester holds it until accepted.
REQ-016 CLR_I=1 SHALL, on the next edge, zero ACC and all flags, force the FSM to IDLE, abort any op in flight with no RES_VLD_O, and block acceptance that cycle; CLR_I has priority over everything.
REQ-017 CLR_I and REQ_VLD_I asserted together in IDLE SHALL result in the request not being accepted.
REQ-018 ACC SHALL wrap modulo 256; carry/borrow semantics are defined by the ALU.

Reset
REQ-019 While RSTN_I=0, the block SHALL set, asynchronously:
- FSM = IDLE
- ACC_O = 0x00 and all FLG_*_O = 0
- RES_VLD_O = 0 and REQ_RDY_O = 1
- ALU_X_O = 0x00, ALU_Y_O = 0x00, ALU_C_O = 0, ALU_OP_O = 000
- all latched request registers = 0
REQ-020 A reset asserted in EXEC or DONE SHALL discard the op in flight; no RES_VLD_O pulse SHALL follow.
REQ-021 After RSTN_I deasserts, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-022 The bench SHALL pair the block with cpu_alu and cover these directed scenarios:
- Reset: hold RSTN_I=0 -> ACC_O=0x00, flags 0, REQ_RDY_O=1, RES_VLD_O=0.
- LDA 0xB3, then ADD 0x6C -> RES_VLD_O 2 edges after each accept; ACC_O=0x1F, FLG_C=1, FLG_Z=0, FLG_S=0, FLG_P matches the ALU's parity output for 0x1F.
- Then ADC 0x00 -> ACC_O=0x20, FLG_C=0; then CMP 0x20 -> ACC_O stays 0x20, FLG_Z=1.
- Hold REQ_VLD_I=1 for back-to-back ops -> accepts spaced exactly 3 cycles apart, no request dropped or duplicated.
- CLR_I with REQ_VLD_I in IDLE -> not accepted, ACC_O=0x00; CLR_I during EXEC -> no RES_VLD_O, FSM in IDLE.
- RSTN_I pulse during EXEC of ADD -> ACC_O=0x00 immediately, no RES_VLD_O, the next request is served normally.
